// File: rtl/secure_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// secure_reg_access_ctrl
//
// Request front-end for the thread-gated secure register. Requests arrive on
// a valid/ready handshake. Only thread 0 is admitted: an admitted request
// produces a single-cycle access strobe and a data response. Any other
// thread gets an error response and counts as a violation. LOCK_THRESH
// consecutive violations close the request port for LOCK_CYCLES cycles.
//
// Optional feature macro: VIOLATION_LOG_EN
//   When defined, adds viol_last_tid (last offending TID) and viol_total
//   (16-bit saturating count of violations). Both are cleared only by rst.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake
//   req_write         1 = write, 0 = read
//   req_tid           requesting thread ID
//   req_wdata         write data
//   resp_valid/ready  response handshake
//   resp_rdata        read data (0 for writes and errors)
//   resp_err          access denied
//   reg_access_en     single-cycle strobe to the register
//   reg_wr_en         write qualifier (only with reg_access_en)
//   reg_wdata         data to the register
//   reg_rdata         register read data, valid with reg_access_en
//   locked            lockout active
// ---------------------------------------------------------------------------
module secure_reg_access_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int TID_WIDTH   = 4,
    parameter int LOCK_THRESH = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [TID_WIDTH-1:0]  req_tid,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  reg_access_en,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  locked
`ifdef VIOLATION_LOG_EN
    ,
    output logic [TID_WIDTH-1:0]  viol_last_tid,
    output logic [15:0]           viol_total
`endif
);

    localparam int VW = $clog2(LOCK_THRESH + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [VW-1:0] THRESH_V  = VW'(LOCK_THRESH);
    localparam logic [LW-1:0] LOCK_INIT = LW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  lat_write;
    logic [TID_WIDTH-1:0]  lat_tid;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [VW-1:0]         viol_cnt;
    logic [LW-1:0]         lock_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake/strobe outputs. The strobe is additionally
    // qualified by the latched TID so no path can ever pulse it for a
    // nonzero thread, whatever state the FSM is in.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        reg_access_en = 1'b0;
        locked        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = (req_tid == '0) ? ISSUE : RESP;
            end
            ISSUE: begin
                reg_access_en = (lat_tid == '0);
                state_d       = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = (viol_cnt == THRESH_V) ? LOCK : IDLE;
            end
            LOCK: begin
                locked = 1'b1;
                if (lock_cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data outputs are forced to zero outside the cycles where they mean
    // something, so nothing latched from a denied request leaks out.
    assign reg_wr_en  = reg_access_en & lat_write;
    assign reg_wdata  = reg_access_en ? lat_wdata : '0;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;

    // Request latch, response data and the violation/lockout counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_write <= 1'b0;
            lat_tid   <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            viol_cnt  <= '0;
            lock_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_tid   <= req_tid;
                        lat_wdata <= req_wdata;
                        if (req_tid != '0) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            if (viol_cnt != THRESH_V) viol_cnt <= viol_cnt + VW'(1);
                        end
                    end
                end
                ISSUE: begin
                    rdata_q  <= lat_write ? '0 : reg_rdata;
                    err_q    <= 1'b0;
                    viol_cnt <= '0;
                end
                RESP: begin
                    if (resp_ready && (viol_cnt == THRESH_V)) begin
                        lock_cnt <= LOCK_INIT;
                        viol_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (lock_cnt != '0) lock_cnt <= lock_cnt - LW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef VIOLATION_LOG_EN
    // Violation log survives lockouts and legal accesses; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_last_tid <= '0;
            viol_total    <= '0;
        end else if (state_q == IDLE && req_valid && req_tid != '0) begin
            viol_last_tid <= req_tid;
            if (viol_total != 16'hFFFF) viol_total <= viol_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_secure_reg_access_ctrl
//
// Directed bench for secure_reg_access_ctrl. A small register model behind
// the strobe stores written data so reads return what thread 0 wrote.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Optional feature macro: VIOLATION_LOG_EN (log outputs checked when set).
// ---------------------------------------------------------------------------
module tb_secure_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_tid = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        reg_access_en;
    logic        reg_wr_en;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        locked;
`ifdef VIOLATION_LOG_EN
    logic [3:0]  viol_last_tid;
    logic [15:0] viol_total;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_reg = '0;

    secure_reg_access_ctrl #(
        .DATA_WIDTH(32), .TID_WIDTH(4), .LOCK_THRESH(3), .LOCK_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tid(req_tid), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .locked(locked)
`ifdef VIOLATION_LOG_EN
        , .viol_last_tid(viol_last_tid), .viol_total(viol_total)
`endif
    );

    always #5 clk = ~clk;

    // Register model: stores on a write strobe, read data is always current.
    always @(posedge clk) if (reg_access_en && reg_wr_en) model_reg <= reg_wdata;
    assign reg_rdata = model_reg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [3:0] t,
                                 input logic [31:0] d, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_tid    = t;
        req_wdata  = d;
        resp_ready = rr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".req_ready"}, req_ready, 1);
        checkOutput({tag, ".resp_valid"}, resp_valid, 0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, 0);
        checkOutput({tag, ".resp_err"}, resp_err, 0);
        checkOutput({tag, ".reg_access_en"}, reg_access_en, 0);
        checkOutput({tag, ".reg_wr_en"}, reg_wr_en, 0);
        checkOutput({tag, ".reg_wdata"}, reg_wdata, 0);
        checkOutput({tag, ".locked"}, locked, 0);
    endtask

    // Denied request from a nonzero TID with resp_ready already high:
    // response on the cycle after acceptance, one-cycle handshake.
    task automatic doViolation(input string tag, input logic [3:0] t, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, t, d, 1'b1);
        checkOutput({tag, ".accept_ready"}, req_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput({tag, ".resp_valid"}, resp_valid, 1);
        checkOutput({tag, ".resp_err"}, resp_err, 1);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, 0);
        checkOutput({tag, ".no_strobe"}, reg_access_en, 0);
        checkOutput({tag, ".no_wr"}, reg_wr_en, 0);
        checkOutput({tag, ".req_ready_low"}, req_ready, 0);
        tick();
    endtask

    // Legal access from TID 0: strobe at N+1, response at N+2.
    task automatic doLegal(input string tag, input logic w, input logic [31:0] d,
                           input logic [31:0] exp_rdata);
        applyStimulus(1'b1, w, 4'd0, d, 1'b1);
        checkOutput({tag, ".accept_ready"}, req_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput({tag, ".strobe"}, reg_access_en, 1);
        checkOutput({tag, ".wr_en"}, reg_wr_en, w);
        checkOutput({tag, ".wdata"}, reg_wdata, w ? d : 32'd0);
        checkOutput({tag, ".no_early_resp"}, resp_valid, 0);
        tick();
        checkOutput({tag, ".resp_valid"}, resp_valid, 1);
        checkOutput({tag, ".resp_err"}, resp_err, 0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        checkOutput({tag, ".strobe_done"}, reg_access_en, 0);
        tick();
        checkOutput({tag, ".back_idle"}, req_ready, 1);
        checkOutput({tag, ".locked"}, locked, 0);
    endtask

    initial begin
        $display("[TB] secure_reg_access_ctrl directed test start");

        // Reset held, then released between edges.
        #3;
        checkIdleOutputs("reset_held");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdleOutputs("reset_released");
        tick();

        // Legal write, then read back through the register model.
        doLegal("wr_deadbeef", 1'b1, 32'hDEADBEEF, 32'd0);
        checkOutput("model_stored", model_reg, 32'hDEADBEEF);

        // Legal read under 10 cycles of response backpressure, with a
        // competing TID 0 request waiting on the port.
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        checkOutput("bp.strobe", reg_access_en, 1);
        checkOutput("bp.wr_en", reg_wr_en, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp.resp_valid", resp_valid, 1);
            checkOutput("bp.resp_rdata", resp_rdata, 32'hDEADBEEF);
            checkOutput("bp.resp_err", resp_err, 0);
            checkOutput("bp.req_ready", req_ready, 0);
            checkOutput("bp.no_strobe", reg_access_en, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("bp.still_valid", resp_valid, 1);
        tick();
        checkOutput("bp.released", resp_valid, 0);
        checkOutput("bp.ready_again", req_ready, 1);

        // Single violation, then a legal read clears the count.
        doViolation("viol_tid5", 4'd5, 32'h12345678);
        checkOutput("viol_tid5.not_locked", locked, 0);
        checkOutput("viol_tid5.model_untouched", model_reg, 32'hDEADBEEF);
        doLegal("rd_clear", 1'b0, 32'd0, 32'hDEADBEEF);

        // 7, 7, 0, 7: the legal access breaks the streak, no lockout.
        doViolation("cr_7a", 4'd7, 32'h0);
        doViolation("cr_7b", 4'd7, 32'h0);
        checkOutput("cr_7b.not_locked", locked, 0);
        doLegal("cr_legal", 1'b0, 32'd0, 32'hDEADBEEF);
        doViolation("cr_7c", 4'd7, 32'h0);
        checkOutput("cr_7c.not_locked", locked, 0);
        checkOutput("cr_7c.ready", req_ready, 1);
        doLegal("pre_lock_clear", 1'b0, 32'd0, 32'hDEADBEEF);

        // Three consecutive TID 3 violations: 16-cycle lockout, during which
        // a waiting TID 0 request must not be taken.
        doViolation("lk_3a", 4'd3, 32'h0);
        doViolation("lk_3b", 4'd3, 32'h0);
        doViolation("lk_3c", 4'd3, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'd0, 32'hCAFEF00D, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("lk.locked", locked, 1);
            checkOutput("lk.req_ready", req_ready, 0);
            checkOutput("lk.no_strobe", reg_access_en, 0);
            checkOutput("lk.no_resp", resp_valid, 0);
            tick();
        end
        checkOutput("lk.unlocked", locked, 0);
        checkOutput("lk.accept_ready", req_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        checkOutput("lk.post_strobe", reg_access_en, 1);
        checkOutput("lk.post_wdata", reg_wdata, 32'hCAFEF00D);
        tick();
        checkOutput("lk.post_resp", resp_valid, 1);
        checkOutput("lk.post_err", resp_err, 0);
        tick();

`ifdef VIOLATION_LOG_EN
        checkOutput("log.total", viol_total, 7);
        checkOutput("log.last_tid", viol_last_tid, 3);
`endif

        // Asynchronous reset while the strobe is up.
        applyStimulus(1'b1, 1'b1, 4'd0, 32'hA5A5A5A5, 1'b1);
        tick();
        checkOutput("ar.strobe_before", reg_access_en, 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkIdleOutputs("ar.immediate");
`ifdef VIOLATION_LOG_EN
        checkOutput("ar.log_total", viol_total, 0);
        checkOutput("ar.log_tid", viol_last_tid, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ar.no_resp", resp_valid, 0);
            checkOutput("ar.no_strobe", reg_access_en, 0);
        end
        checkOutput("ar.model_kept", model_reg, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/secure_reg_access_ctrl.md
Name: secure_reg_access_ctrl

Overview:
- Request front-end that sits directly upstream of the thread-gated secure register.
- Accepts read/write requests from multiple hardware threads over a valid/ready handshake and checks the requesting thread ID; only thread 0 is allowed through.
- For each admitted request it issues a single-cycle access strobe to the register, and it returns a response with data or an error.
- Repeated violations trigger a timed lockout of the request port.

Parameters:
- DATA_WIDTH, 32, width of register data.
- TID_WIDTH, 4, width of thread ID.
- LOCK_THRESH, 3, number of consecutive violations that triggers lockout (at least 1).
- LOCK_CYCLES, 16, lockout duration in clk cycles (at least 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_tid  input  TID_WIDTH  requesting thread ID.
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  response consumed.
- resp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- resp_err  output  1  access denied.
- reg_access_en  output  1  single-cycle access strobe to the register.
- reg_wr_en  output  1  write qualifier; only ever high while reg_access_en is high.
- reg_wdata  output  DATA_WIDTH  data to the register.
- reg_rdata  input  DATA_WIDTH  register read data; valid in the same cycle as reg_access_en.
- locked  output  1  lockout active.

Behaviour:
- Reset state, while rst is high and immediately after it falls:
  - FSM is in IDLE.
  - All outputs are 0, except req_ready, which is 1.
  - Violation counter and lock counter are 0.
- FSM states are IDLE, ISSUE, RESP and LOCK.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch req_write, req_tid and req_wdata.
  - If req_tid == 0, go to ISSUE.
  - Otherwise (violation), go to RESP with err = 1 and rdata = 0, and increment the violation counter, saturating at LOCK_THRESH.
- ISSUE (exactly one cycle):
  - reg_access_en = 1, reg_wr_en = latched write bit, reg_wdata = latched data.
  - Capture reg_rdata at the clock edge for reads; load 0 for writes.
  - Clear the violation counter.
  - Go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready.
  - req_ready = 0.
  - On resp_ready: if the violation counter == LOCK_THRESH, go to LOCK, load the lock counter with LOCK_CYCLES-1 and clear the violation counter; otherwise go to IDLE.
- LOCK:
  - locked = 1, req_ready = 0.
  - The lock counter decrements each cycle; when it reaches 0, go to IDLE (locked is low from that cycle).
  - Lockout lasts exactly LOCK_CYCLES cycles.
- Latency, with acceptance at cycle N:
  - Legal request: strobe at N+1, resp_valid at N+2.
  - Violation: resp_valid at N+1; no strobe ever.
- Throughput and ordering:
  - At most one request is in flight.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Strobe protection: reg_access_en and reg_wr_en are never asserted for a nonzero TID, in any state, including LOCK.
- Reset mid-operation: any state returns asynchronously to IDLE. The pending request is dropped with no response and no strobe; counters are cleared.
- resp_ready held high on entry to RESP completes the handshake in that same cycle (one-cycle response).

Optional Feature:
- VIOLATION_LOG_EN
- Defined:
  - Adds outputs viol_last_tid (TID_WIDTH) and viol_total (16 bits, saturating at 0xFFFF).
  - On every violation acceptance, viol_last_tid takes the offending TID and viol_total increments.
  - Both are cleared only by rst, not by lockout or by legal accesses.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Legal write and read-back:
  - TID 0 writes 0xDEADBEEF → reg_access_en=1, reg_wr_en=1, reg_wdata=0xDEADBEEF at N+1; resp_valid at N+2 with err=0, rdata=0.
  - TID 0 read with reg_rdata=0xDEADBEEF → resp_rdata=0xDEADBEEF.
- Violation: TID 5 write of 0x12345678 → no strobe at any cycle; resp_valid at N+1 with err=1, rdata=0.
- Lockout: three consecutive TID 3 requests → after the third response, locked=1 and req_ready=0 for exactly 16 cycles; a request from TID 0 during lockout is not accepted; it is accepted on the first cycle after lockout ends.
- Counter reset: TID 7, TID 7, TID 0, TID 7 → no lockout, because the legal access cleared the count.
- Backpressure: hold resp_ready=0 for 10 cycles after a legal read → resp_valid, resp_rdata and resp_err stay stable; req_ready=0; no second strobe.
- Async reset: assert rst during ISSUE → outputs go to reset values immediately; no resp_valid after release; with VIOLATION_LOG_EN, viol_total=0.
